// File: rtl/byte_arb_pkg.sv
// Shared types for the byte round-robin arbiter.
//   byte_t      - one beat of payload
//   src_t       - requester index (up to 8 requesters)
//   arb_state_t - arbiter FSM state
package byte_arb_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] src_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker. Purely combinational.
// Ports:
//   req        in   N_REQ  request vector
//   last_grant in   src_t  requester served most recently
//   pick       out  src_t  first set index scanning upward from last_grant+1
//   found      out  1      at least one request bit is set
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  byte_arb_pkg::src_t last_grant,
    output byte_arb_pkg::src_t pick,
    output logic               found
);
    import byte_arb_pkg::*;

    int off;
    int best;

    // Each index gets its distance from last_grant+1 around the ring; the
    // smallest distance among the set bits wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        best  = N_REQ;
        off   = 0;
        for (int j = 0; j < N_REQ; j++) begin
            off = (j + 2 * N_REQ - int'(last_grant) - 1) % N_REQ;
            if (req[j] && (off < best)) begin
                best  = off;
                pick  = src_t'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_REQ byte streams into one
// registered output stream. A grant is held for a whole packet; packets
// longer than MAX_BEATS are cut and the sticky err_overlen flag is raised.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_data/req_last    per-requester beat inputs
//   req_ready                      per-requester accept (only the granted bit)
//   out_valid/out_data/out_src/out_last  registered output beat
//   out_ready                      downstream accept
//   err_overlen                    sticky: a packet was truncated
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitration cycle; no beat accepted, winner registered into grant
// BUSY  | forwarding beats of the granted requester until out_last goes out
module byte_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_valid,
    input  byte_arb_pkg::byte_t [N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]                  req_last,
    output logic [N_REQ-1:0]                  req_ready,
    output logic                              out_valid,
    output byte_arb_pkg::byte_t               out_data,
    output byte_arb_pkg::src_t                out_src,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic                              err_overlen
);
    import byte_arb_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

    arb_state_t state, state_nxt;
    src_t       grant, grant_nxt;
    src_t       last_grant, last_grant_nxt;
    logic [7:0] beat_cnt;

    src_t  pick;
    logic  found;
    logic  g_valid;
    logic  g_last;
    byte_t g_data;
    logic  accept_ok;
    logic  xfer;
    logic  force_end;
    logic  beat_last;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .found      (found)
    );

    // Granted requester's inputs, selected by comparison rather than by
    // indexing so the 3-bit grant never addresses past N_REQ.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == src_t'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign accept_ok = !out_valid || out_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((state == BUSY) && (grant == src_t'(i))) begin
                req_ready[i] = accept_ok;
            end
        end
    end

    assign xfer      = (state == BUSY) && g_valid && accept_ok;
    assign force_end = (beat_cnt == LAST_IDX);
    assign beat_last = g_last || force_end;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    grant_nxt = pick;
                end
            end
            BUSY: begin
                if (xfer && beat_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= src_t'(N_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Counter clears on the beat that ends the packet, which is exactly
    // the transfer that sends the FSM back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= '0;
            out_last    <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_src   <= grant;
                out_last  <= beat_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && force_end && !g_last) begin
                err_overlen <= 1'b1;
            end
        end
    end

endmodule
